control_sequencer: RTL and testbench

Moore-style control step generator for the 32-bit datapath. It walks each instruction through fetch (T0–T2) and per-class execute steps (T3–T7), and drives the register-select strobes (Gra/Grb/Grc, Rin/Rout/BAout) consumed by the IR select-and-encode logic. It also drives the PC, MAR, MDR, Y, Z, HI/LO and memory strobes. It sits directly upstream of the IR select logic and takes `opcode[4:0]` back from it.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control-sequencer bundle: opcode/handshake inputs from the IR and memory side,
// plus every strobe the sequencer drives into the datapath.
interface control_sequencer_if;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       stop;

    logic       Gra, Grb, Grc;
    logic       Rin, Rout, BAout;
    logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic       Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout;
    logic       Read, Write;
    logic [4:0] alu_op;
    logic       run;
    logic       illegal;

    // Sequencer side: consumes opcode/handshakes, produces strobes
    modport master (
        input  opcode, mem_ready, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout,
        output Read, Write, alu_op, run, illegal
    );

    // Datapath side: supplies opcode/handshakes, consumes strobes
    modport slave (
        output opcode, mem_ready, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout,
        input  Read, Write, alu_op, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control-step generator: fetch T0-T2, per-class execute T3-T7, HALT.
// Strobes are a pure decode of the step register and the opcode held in the IR.
module control_sequencer (
    input  logic                       clock,
    input  logic                       reset_n,
    control_sequencer_if.master        bus
);

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_T6    = 4'd7;
    localparam logic [3:0] ST_T7    = 4'd8;
    localparam logic [3:0] ST_HALT  = 4'd9;

    localparam logic [3:0] CL_ALU    = 4'd0;
    localparam logic [3:0] CL_IMM    = 4'd1;
    localparam logic [3:0] CL_LD     = 4'd2;
    localparam logic [3:0] CL_ST     = 4'd3;
    localparam logic [3:0] CL_MULDIV = 4'd4;
    localparam logic [3:0] CL_NEGNOT = 4'd5;
    localparam logic [3:0] CL_NOP    = 4'd6;
    localparam logic [3:0] CL_HALT   = 4'd7;
    localparam logic [3:0] CL_RSVD   = 4'd8;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    function automatic logic [3:0] op_class(input logic [4:0] op);
        logic [3:0] cls;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10:       cls = CL_ALU;
            5'd1, 5'd11, 5'd12, 5'd13:     cls = CL_IMM;
            5'd0:                          cls = CL_LD;
            5'd2:                          cls = CL_ST;
            5'd14, 5'd15:                  cls = CL_MULDIV;
            5'd16, 5'd17:                  cls = CL_NEGNOT;
            5'd25:                         cls = CL_NOP;
            5'd26:                         cls = CL_HALT;
            default:                       cls = CL_RSVD;
        endcase
        return cls;
    endfunction

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, irin;
        logic yin, zin, zlowout, zhighout, hiin, loin, cout;
        logic read, write, run, illegal;
    } strobes_t;

    logic [3:0] state_q, state_d;
    logic [3:0] step_s;
    logic [3:0] class_s;
    logic       last_s;
    strobes_t   out_s;
    logic [4:0] alu_s;

    assign class_s = op_class(bus.opcode);

    // Step register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step; last_s marks an instruction boundary where stop is honoured
    always_comb begin
        step_s = state_q;
        last_s = 1'b0;
        case (state_q)
            ST_RESET: step_s = ST_T0;
            ST_T0:    step_s = ST_T1;
            ST_T1:    step_s = bus.mem_ready ? ST_T2 : ST_T1;
            ST_T2:    step_s = ST_T3;
            ST_T3: begin
                case (class_s)
                    CL_HALT:         step_s = ST_HALT;
                    CL_NOP, CL_RSVD: last_s = 1'b1;
                    default:         step_s = ST_T4;
                endcase
            end
            ST_T4: begin
                case (class_s)
                    CL_ALU, CL_IMM, CL_LD, CL_ST, CL_MULDIV: step_s = ST_T5;
                    default:                                 last_s = 1'b1;
                endcase
            end
            ST_T5: begin
                case (class_s)
                    CL_LD, CL_ST, CL_MULDIV: step_s = ST_T6;
                    default:                 last_s = 1'b1;
                endcase
            end
            ST_T6: begin
                case (class_s)
                    CL_LD:   step_s = bus.mem_ready ? ST_T7 : ST_T6;
                    CL_ST:   step_s = ST_T7;
                    default: last_s = 1'b1;
                endcase
            end
            ST_T7: begin
                case (class_s)
                    CL_ST: begin
                        last_s = bus.mem_ready;
                        step_s = ST_T7;
                    end
                    default: last_s = 1'b1;
                endcase
            end
            ST_HALT:  step_s = ST_HALT;
            default:  step_s = ST_RESET;
        endcase
        state_d = last_s ? (bus.stop ? ST_HALT : ST_T0) : step_s;
    end

    // Strobe decode from step and instruction class
    always_comb begin
        out_s = '0;
        alu_s = 5'd0;
        case (state_q)
            ST_T0: begin
                out_s.pcout = 1'b1;
                out_s.marin = 1'b1;
                out_s.incpc = 1'b1;
                out_s.zin   = 1'b1;
                alu_s       = ALU_ADD;
            end
            ST_T1: begin
                out_s.zlowout = 1'b1;
                out_s.pcin    = 1'b1;
                out_s.read    = 1'b1;
                out_s.mdrin   = 1'b1;
            end
            ST_T2: begin
                out_s.mdrout = 1'b1;
                out_s.irin   = 1'b1;
            end
            ST_T3: begin
                alu_s = bus.opcode;
                case (class_s)
                    CL_ALU: begin
                        out_s.grb  = 1'b1;
                        out_s.rout = 1'b1;
                        out_s.yin  = 1'b1;
                    end
                    CL_IMM, CL_LD, CL_ST: begin
                        out_s.grb   = 1'b1;
                        out_s.baout = 1'b1;
                        out_s.yin   = 1'b1;
                        alu_s       = (class_s == CL_IMM) ? bus.opcode : ALU_ADD;
                    end
                    CL_MULDIV: begin
                        out_s.gra  = 1'b1;
                        out_s.rout = 1'b1;
                        out_s.yin  = 1'b1;
                    end
                    CL_NEGNOT: begin
                        out_s.grb  = 1'b1;
                        out_s.rout = 1'b1;
                        out_s.zin  = 1'b1;
                    end
                    CL_RSVD: out_s.illegal = 1'b1;
                    default: out_s.illegal = 1'b0;
                endcase
            end
            ST_T4: begin
                alu_s = bus.opcode;
                case (class_s)
                    CL_ALU: begin
                        out_s.grc  = 1'b1;
                        out_s.rout = 1'b1;
                        out_s.zin  = 1'b1;
                    end
                    CL_IMM, CL_LD, CL_ST: begin
                        out_s.cout = 1'b1;
                        out_s.zin  = 1'b1;
                        alu_s      = (class_s == CL_IMM) ? bus.opcode : ALU_ADD;
                    end
                    CL_MULDIV: begin
                        out_s.grb  = 1'b1;
                        out_s.rout = 1'b1;
                        out_s.zin  = 1'b1;
                    end
                    CL_NEGNOT: begin
                        out_s.zlowout = 1'b1;
                        out_s.gra     = 1'b1;
                        out_s.rin     = 1'b1;
                    end
                    default: out_s.zin = 1'b0;
                endcase
            end
            ST_T5: begin
                alu_s         = bus.opcode;
                out_s.zlowout = 1'b1;
                case (class_s)
                    CL_ALU, CL_IMM: begin
                        out_s.gra = 1'b1;
                        out_s.rin = 1'b1;
                    end
                    CL_LD, CL_ST: out_s.marin   = 1'b1;
                    CL_MULDIV:    out_s.loin    = 1'b1;
                    default:      out_s.zlowout = 1'b0;
                endcase
            end
            ST_T6: begin
                alu_s = bus.opcode;
                case (class_s)
                    CL_LD: begin
                        out_s.read  = 1'b1;
                        out_s.mdrin = 1'b1;
                    end
                    CL_ST: begin
                        out_s.gra   = 1'b1;
                        out_s.rout  = 1'b1;
                        out_s.mdrin = 1'b1;
                    end
                    CL_MULDIV: begin
                        out_s.zhighout = 1'b1;
                        out_s.hiin     = 1'b1;
                    end
                    default: out_s.read = 1'b0;
                endcase
            end
            ST_T7: begin
                alu_s = bus.opcode;
                case (class_s)
                    CL_LD: begin
                        out_s.mdrout = 1'b1;
                        out_s.gra    = 1'b1;
                        out_s.rin    = 1'b1;
                    end
                    CL_ST:   out_s.write = 1'b1;
                    default: out_s.write = 1'b0;
                endcase
            end
            default: alu_s = 5'd0;
        endcase
        out_s.run = (state_q != ST_RESET) && (state_q != ST_HALT);
    end

    assign bus.Gra      = out_s.gra;
    assign bus.Grb      = out_s.grb;
    assign bus.Grc      = out_s.grc;
    assign bus.Rin      = out_s.rin;
    assign bus.Rout     = out_s.rout;
    assign bus.BAout    = out_s.baout;
    assign bus.PCout    = out_s.pcout;
    assign bus.PCin     = out_s.pcin;
    assign bus.IncPC    = out_s.incpc;
    assign bus.MARin    = out_s.marin;
    assign bus.MDRin    = out_s.mdrin;
    assign bus.MDRout   = out_s.mdrout;
    assign bus.IRin     = out_s.irin;
    assign bus.Yin      = out_s.yin;
    assign bus.Zin      = out_s.zin;
    assign bus.Zlowout  = out_s.zlowout;
    assign bus.Zhighout = out_s.zhighout;
    assign bus.HIin     = out_s.hiin;
    assign bus.LOin     = out_s.loin;
    assign bus.Cout     = out_s.cout;
    assign bus.Read     = out_s.read;
    assign bus.Write    = out_s.write;
    assign bus.run      = out_s.run;
    assign bus.illegal  = out_s.illegal;
    assign bus.alu_op   = alu_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step tables built from the
// instruction-class rules, compared cycle by cycle against the DUT strobes.
module tb_control_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Observation vector: alu_op in [4:0], then one bit per strobe
    localparam logic [28:0] GRA   = 29'd1 << 5;
    localparam logic [28:0] GRB   = 29'd1 << 6;
    localparam logic [28:0] GRC   = 29'd1 << 7;
    localparam logic [28:0] RIN   = 29'd1 << 8;
    localparam logic [28:0] ROUT  = 29'd1 << 9;
    localparam logic [28:0] BAOUT = 29'd1 << 10;
    localparam logic [28:0] PCOUT = 29'd1 << 11;
    localparam logic [28:0] PCIN  = 29'd1 << 12;
    localparam logic [28:0] INCPC = 29'd1 << 13;
    localparam logic [28:0] MARIN = 29'd1 << 14;
    localparam logic [28:0] MDRIN = 29'd1 << 15;
    localparam logic [28:0] MDROUT= 29'd1 << 16;
    localparam logic [28:0] IRIN  = 29'd1 << 17;
    localparam logic [28:0] YIN   = 29'd1 << 18;
    localparam logic [28:0] ZIN   = 29'd1 << 19;
    localparam logic [28:0] ZLOW  = 29'd1 << 20;
    localparam logic [28:0] ZHIGH = 29'd1 << 21;
    localparam logic [28:0] HIIN  = 29'd1 << 22;
    localparam logic [28:0] LOIN  = 29'd1 << 23;
    localparam logic [28:0] COUT  = 29'd1 << 24;
    localparam logic [28:0] READ  = 29'd1 << 25;
    localparam logic [28:0] WRITE = 29'd1 << 26;
    localparam logic [28:0] ILL   = 29'd1 << 27;
    localparam logic [28:0] RUN   = 29'd1 << 28;
    localparam logic [28:0] ADD   = 29'd3;

    int          checks = 0;
    int          errors = 0;
    logic [28:0] seq_v[$];
    bit          seq_w[$];
    logic [28:0] obs_q[$];
    logic [28:0] exp_q[$];
    int          ncyc;
    bit          halted;

    function automatic logic [28:0] sample();
        return {bus.run, bus.illegal, bus.Write, bus.Read, bus.Cout, bus.LOin, bus.HIin,
                bus.Zhighout, bus.Zlowout, bus.Zin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin,
                bus.MARin, bus.IncPC, bus.PCin, bus.PCout, bus.BAout, bus.Rout, bus.Rin,
                bus.Grc, bus.Grb, bus.Gra, bus.alu_op};
    endfunction

    function automatic void push(input logic [28:0] v, input bit w);
        seq_v.push_back(v | RUN);
        seq_w.push_back(w);
    endfunction

    // Step table for one instruction; w marks a step that stretches while mem_ready is low
    function automatic void build(input logic [4:0] op);
        logic [28:0] a;
        a = {24'd0, op};
        seq_v.delete();
        seq_w.delete();
        push(PCOUT | MARIN | INCPC | ZIN | ADD, 1'b0);
        push(ZLOW | PCIN | READ | MDRIN, 1'b1);
        push(MDROUT | IRIN, 1'b0);
        if (op >= 5'd3 && op <= 5'd10) begin
            push(GRB | ROUT | YIN | a, 1'b0);
            push(GRC | ROUT | ZIN | a, 1'b0);
            push(ZLOW | GRA | RIN | a, 1'b0);
        end else if (op == 5'd1 || (op >= 5'd11 && op <= 5'd13)) begin
            push(GRB | BAOUT | YIN | a, 1'b0);
            push(COUT | ZIN | a, 1'b0);
            push(ZLOW | GRA | RIN | a, 1'b0);
        end else if (op == 5'd0 || op == 5'd2) begin
            push(GRB | BAOUT | YIN | ADD, 1'b0);
            push(COUT | ZIN | ADD, 1'b0);
            push(ZLOW | MARIN | a, 1'b0);
            if (op == 5'd0) begin
                push(READ | MDRIN | a, 1'b1);
                push(MDROUT | GRA | RIN | a, 1'b0);
            end else begin
                push(GRA | ROUT | MDRIN | a, 1'b0);
                push(WRITE | a, 1'b1);
            end
        end else if (op == 5'd14 || op == 5'd15) begin
            push(GRA | ROUT | YIN | a, 1'b0);
            push(GRB | ROUT | ZIN | a, 1'b0);
            push(ZLOW | LOIN | a, 1'b0);
            push(ZHIGH | HIIN | a, 1'b0);
        end else if (op == 5'd16 || op == 5'd17) begin
            push(GRB | ROUT | ZIN | a, 1'b0);
            push(ZLOW | GRA | RIN | a, 1'b0);
        end else if (op == 5'd25 || op == 5'd26) begin
            push(a, 1'b0);
        end else begin
            push(ILL | a, 1'b0);
        end
    endfunction

    // Drives one instruction from T0; zeros = forced mem_ready-low cycles in the execute wait step
    task automatic run_instr(input logic [4:0] op, input bit rnd, input int zeros, input int stop_at);
        int idx = 0;
        int stall = 0;
        int zl = zeros;
        bit mr;
        bit st;
        build(op);
        obs_q.delete();
        exp_q.delete();
        halted = 1'b0;
        ncyc = 0;
        while (idx < seq_v.size()) begin
            @(negedge clock);
            bus.opcode = (idx < 3) ? 5'($urandom) : op;
            if (!seq_w[idx])          mr = 1'($urandom_range(0, 1));
            else if (rnd)             mr = (stall >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            else if (idx >= 3 && zl > 0) begin mr = 1'b0; zl--; end
            else                      mr = 1'b1;
            st = (stop_at >= 0) && (ncyc >= stop_at);
            bus.mem_ready = mr;
            bus.stop = st;
            #1;
            obs_q.push_back(sample());
            exp_q.push_back(seq_v[idx]);
            ncyc++;
            if (seq_w[idx] && !mr) begin
                stall++;
            end else begin
                stall = 0;
                if (idx == seq_v.size() - 1 && (st || op == 5'd26)) halted = 1'b1;
                idx++;
            end
        end
        if (halted) begin
            repeat (2) begin
                @(negedge clock);
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.stop = 1'b0;
                #1;
                obs_q.push_back(sample());
                exp_q.push_back(29'd0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        bus.stop = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.opcode = 5'd3;
        bus.mem_ready = 1'b1;
        bus.stop = 1'b0;
        #12;
        checks++;
        if (sample() !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", sample());
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.run !== 1'b0) begin
            errors++;
            $display("FAIL reset_run got %b want 0", bus.run);
        end
    endtask

    task automatic test_add();
        run_instr(5'd3, 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL add cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ncyc !== 6) begin errors++; $display("FAIL add_latency got %0d want 6", ncyc); end
    endtask

    task automatic test_ld_wait();
        run_instr(5'd0, 1'b0, 2, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ld_wait cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ncyc !== 10) begin errors++; $display("FAIL ld_latency got %0d want 10", ncyc); end
    endtask

    task automatic test_st();
        int writes = 0;
        int gra_rin = 0;
        run_instr(5'd2, 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL st cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][26]) writes++;
            if (obs_q[i][5] && obs_q[i][8]) gra_rin++;
        end
        checks++;
        if (ncyc !== 8 || writes !== 1 || gra_rin !== 0) begin
            errors++;
            $display("FAIL st_summary got cyc=%0d wr=%0d gra_rin=%0d want 8 1 0", ncyc, writes, gra_rin);
        end
    endtask

    task automatic test_illegal_halt();
        int ill = 0;
        run_instr(5'd22, 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][27]) ill++;
        end
        checks++;
        if (ncyc !== 4 || ill !== 1) begin
            errors++;
            $display("FAIL illegal_summary got cyc=%0d pulses=%0d want 4 1", ncyc, ill);
        end
        run_instr(5'd26, 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL halt cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        // Short reset pulse inside HALT: back to RESET, then a fresh fetch
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        checks++;
        if (sample() !== 29'd0) begin errors++; $display("FAIL halt_reset got %h want 0", sample()); end
        run_instr(5'd25, 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL after_halt cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stop();
        do_reset();
        run_instr(5'd3, 1'b0, 0, 4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stop cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (exp_q.size() !== 8) begin errors++; $display("FAIL stop_length got %0d want 8", exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.opcode = 5'd0;
        repeat (6) begin
            @(negedge clock);
            bus.mem_ready = 1'b1;
        end
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.Read !== 1'b1) begin errors++; $display("FAIL midwait_read got %b want 1", bus.Read); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (sample() !== 29'd0) begin errors++; $display("FAIL midwait_reset got %h want 0", sample()); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] op;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26) op = 5'd25;
            run_instr(op, 1'b1, 0, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || (obs_q[i][8] && obs_q[i][9])) begin
                    errors++;
                    $display("FAIL random op=%0d cycle %0d got %h want %h", op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        bus.opcode = 5'd0;
        bus.mem_ready = 1'b1;
        bus.stop = 1'b0;
        test_reset();
        test_add();
        test_ld_wait();
        test_st();
        test_illegal_halt();
        test_stop();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
